// File: rtl/led7seg_74hc595_frame_capture.sv
// Oversamples the 74HC595 sclk/rclk/dio chain, deserializes each latched frame and rebuilds the display image.
// Optional segment-to-digit decode outputs (hex, dec_err) are enabled by defining SEG_DECODE_EN.
module led7seg_74hc595_frame_capture #(
   parameter int DIG_NUM = 8,
   parameter int SEG_NUM = 8,
   localparam int CHA_WIDTH = DIG_NUM + SEG_NUM,
   localparam int DAT_WIDTH = SEG_NUM * DIG_NUM
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sclk_in,
   input  logic                 rclk_in,
   input  logic                 dio_in,
   output logic [DAT_WIDTH-1:0] dat,
   output logic                 dat_vld,
   output logic                 frm_err,
   output logic                 sel_err,
`ifdef SEG_DECODE_EN
   output logic [4*DIG_NUM-1:0] hex,
   output logic [DIG_NUM-1:0]   dec_err,
`endif
   output logic [15:0]          scan_cnt
);

   localparam int CNT_W = $clog2(CHA_WIDTH + 2);
   localparam int K_W   = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;

   // [0],[1] synchronize; [2] holds the previous synchronized level for edge detection
   logic [2:0]           sclk_sr;
   logic [2:0]           rclk_sr;
   logic [1:0]           dio_sr;
   logic [CHA_WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0]     bit_cnt;
   logic [DIG_NUM-1:0]   mask;
   logic [DAT_WIDTH-1:0] stage;

   logic                 sclk_rise;
   logic                 rclk_rise;
   logic [CHA_WIDTH-1:0] shift_nxt;
   logic [CNT_W-1:0]     cnt_nxt;
   logic [SEG_NUM-1:0]   seg;
   logic [DIG_NUM-1:0]   sel;
   logic                 cnt_ok;
   logic                 wr_en;
   logic [K_W-1:0]       wr_idx;
   logic                 mask_full;

   assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
   assign rclk_rise = rclk_sr[1] & ~rclk_sr[2];
   assign mask_full = &mask;

   // Latch sees the post-shift register so a coincident sclk edge is included in the frame
   always_comb begin
      shift_nxt = shift_reg;
      cnt_nxt   = bit_cnt;
      if (sclk_rise) begin
         shift_nxt = {shift_reg[CHA_WIDTH-2:0], dio_sr[1]};
         if (bit_cnt != CNT_W'(CHA_WIDTH + 1))
            cnt_nxt = bit_cnt + CNT_W'(1);
      end
      seg    = shift_nxt[CHA_WIDTH-1:DIG_NUM];
      sel    = shift_nxt[DIG_NUM-1:0];
      cnt_ok = (cnt_nxt == CNT_W'(CHA_WIDTH));
      wr_en  = rclk_rise && cnt_ok && $onehot(sel);
      wr_idx = '0;
      for (int i = 0; i < DIG_NUM; i++)
         if (sel[i]) wr_idx = K_W'(i);
   end

`ifdef SEG_DECODE_EN
   // Active-low {dp,g,f,e,d,c,b,a}; dp forced off before matching
   function automatic logic [4:0] dec7(input logic [SEG_NUM-1:0] s);
      case ({1'b1, s[6:0]})
         8'hC0:   dec7 = {1'b0, 4'h0};
         8'hF9:   dec7 = {1'b0, 4'h1};
         8'hA4:   dec7 = {1'b0, 4'h2};
         8'hB0:   dec7 = {1'b0, 4'h3};
         8'h99:   dec7 = {1'b0, 4'h4};
         8'h92:   dec7 = {1'b0, 4'h5};
         8'h82:   dec7 = {1'b0, 4'h6};
         8'hF8:   dec7 = {1'b0, 4'h7};
         8'h80:   dec7 = {1'b0, 4'h8};
         8'h90:   dec7 = {1'b0, 4'h9};
         default: dec7 = {1'b1, 4'hF};
      endcase
   endfunction
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sr   <= '0;
         rclk_sr   <= '0;
         dio_sr    <= '0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         mask      <= '0;
         stage     <= '0;
         dat       <= '0;
         dat_vld   <= 1'b0;
         frm_err   <= 1'b0;
         sel_err   <= 1'b0;
         scan_cnt  <= '0;
`ifdef SEG_DECODE_EN
         hex       <= '0;
         dec_err   <= '0;
`endif
      end else begin
         sclk_sr   <= {sclk_sr[1:0], sclk_in};
         rclk_sr   <= {rclk_sr[1:0], rclk_in};
         dio_sr    <= {dio_sr[0], dio_in};
         shift_reg <= shift_nxt;
         bit_cnt   <= rclk_rise ? '0 : cnt_nxt;
         frm_err   <= rclk_rise && !cnt_ok;
         sel_err   <= rclk_rise && cnt_ok && !$onehot(sel);
         dat_vld   <= mask_full;

         if (wr_en)
            stage[SEG_NUM*wr_idx +: SEG_NUM] <= seg;
         mask <= (mask_full ? '0 : mask) | (wr_en ? sel : '0);

         if (mask_full) begin
            dat      <= stage;
            scan_cnt <= scan_cnt + 16'd1;
`ifdef SEG_DECODE_EN
            for (int i = 0; i < DIG_NUM; i++)
               {dec_err[i], hex[4*i +: 4]} <= dec7(stage[SEG_NUM*i +: SEG_NUM]);
`endif
         end
      end
   end

endmodule

// File: tb/tb_led7seg_74hc595_frame_capture.sv
// Randomized frame stimulus against a frame-level model of the display capture.
module tb_led7seg_74hc595_frame_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk_in = 1'b0;
   logic        rclk_in = 1'b0;
   logic        dio_in = 1'b0;
   logic [63:0] dat;
   logic        dat_vld;
   logic        frm_err;
   logic        sel_err;
   logic [15:0] scan_cnt;
`ifdef SEG_DECODE_EN
   logic [31:0] hex;
   logic [7:0]  dec_err;
`endif

   led7seg_74hc595_frame_capture #(.DIG_NUM(8), .SEG_NUM(8)) dut (
      .clk(clk), .rst(rst), .sclk_in(sclk_in), .rclk_in(rclk_in), .dio_in(dio_in),
      .dat(dat), .dat_vld(dat_vld), .frm_err(frm_err), .sel_err(sel_err),
`ifdef SEG_DECODE_EN
      .hex(hex), .dec_err(dec_err),
`endif
      .scan_cnt(scan_cnt));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Frame-level model: bits sent since last latch, staging bytes, refresh set, scheduled pulses
   bit          sent[$];
   logic [7:0]  stg[8];
   bit          seen[8];
   bit          frm_at[int];
   bit          sel_at[int];
   logic [63:0] img_at[int];
   logic [63:0] exp_dat  = '0;
   logic [15:0] exp_scan = '0;
   logic [31:0] exp_hex  = '0;
   logic [7:0]  exp_derr = '0;

   const logic [7:0] digit_pat[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   task automatic model_clear();
      sent.delete();
      frm_at.delete();
      sel_at.delete();
      img_at.delete();
      for (int i = 0; i < 8; i++) begin
         stg[i]  = '0;
         seen[i] = 1'b0;
      end
      exp_dat  = '0;
      exp_scan = '0;
      exp_hex  = '0;
      exp_derr = '0;
   endtask

   task automatic model_latch(input int c);
      logic [15:0] f;
      logic [7:0]  sel;
      int          k;
      bit          all;
      f = '0;
      foreach (sent[i]) f = {f[14:0], sent[i]};
      sel = f[7:0];
      if (sent.size() != 16) frm_at[c + 3] = 1'b1;
      else if ($countones(sel) != 1) sel_at[c + 3] = 1'b1;
      else begin
         k = 0;
         for (int i = 0; i < 8; i++) if (sel[i]) k = i;
         stg[k]  = f[15:8];
         seen[k] = 1'b1;
         all = 1'b1;
         for (int i = 0; i < 8; i++) all &= seen[i];
         if (all) begin
            img_at[c + 4] = {stg[7], stg[6], stg[5], stg[4], stg[3], stg[2], stg[1], stg[0]};
            for (int i = 0; i < 8; i++) seen[i] = 1'b0;
         end
      end
      sent.delete();
   endtask

   always @(negedge clk) begin
      if (img_at.exists(cyc)) begin
         exp_dat  = img_at[cyc];
         exp_scan = exp_scan + 16'd1;
         for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = exp_dat[8*i +: 8] | 8'h80;
            exp_hex[4*i +: 4] = 4'hF;
            exp_derr[i]       = 1'b1;
            for (int d = 0; d < 10; d++)
               if (b == digit_pat[d]) begin
                  exp_hex[4*i +: 4] = 4'(d);
                  exp_derr[i]       = 1'b0;
               end
         end
      end
      chk("dat_vld",  {63'd0, dat_vld}, {63'd0, img_at.exists(cyc)});
      chk("frm_err",  {63'd0, frm_err}, {63'd0, frm_at.exists(cyc)});
      chk("sel_err",  {63'd0, sel_err}, {63'd0, sel_at.exists(cyc)});
      chk("dat",      dat, exp_dat);
      chk("scan_cnt", {48'd0, scan_cnt}, {48'd0, exp_scan});
`ifdef SEG_DECODE_EN
      chk("hex",      {32'd0, hex}, {32'd0, exp_hex});
      chk("dec_err",  {56'd0, dec_err}, {56'd0, exp_derr});
`endif
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         sclk_in = 1'b0;
         dio_in  = v[i];
         tick(3);
         sclk_in = 1'b1;
         sent.push_back(v[i]);
         tick(3);
      end
      sclk_in = 1'b0;
      tick(3);
   endtask

   task automatic latch();
      rclk_in = 1'b1;
      model_latch(cyc);
      tick(3);
      rclk_in = 1'b0;
      tick(3);
   endtask

   task automatic send_frame(input logic [7:0] seg, input logic [7:0] sel);
      send_bits({16'd0, seg, sel}, 16);
      latch();
   endtask

   initial begin
      model_clear();
      tick(4);
      rst = 1'b0;
      tick(2);

      for (int k = 0; k < 8; k++) send_frame(8'hC0 + 8'(k), 8'(1 << k));
      tick(4);
      for (int k = 0; k < 8; k++) chk("lit_scan1_dat", {56'd0, dat[8*k +: 8]}, {56'd0, 8'hC0 + 8'(k)});
      chk("lit_scan1_cnt", {48'd0, scan_cnt}, 64'd1);

      send_bits(32'h0000_7FFF, 15);
      latch();
      send_frame(8'hF9, 8'h01);
      send_frame(8'h12, 8'b0000_0011);
      send_frame(8'h34, 8'h00);

      send_frame(8'hA4, 8'h08);
      send_frame(8'hB0, 8'h08);
      for (int k = 0; k < 8; k++) if (k != 3) send_frame(8'h50 + 8'(k), 8'(1 << k));
      tick(4);
      chk("lit_dig3_dat", {56'd0, dat[31:24]}, 64'hB0);
      chk("lit_scan2_cnt", {48'd0, scan_cnt}, 64'd2);

      send_bits(32'h0000_01A5, 9);
      rst = 1'b1;
      model_clear();
      tick(4);
      rst = 1'b0;
      tick(2);
      send_frame(8'h99, 8'h04);

      for (int k = 0; k < 8; k++) send_frame((k == 0) ? 8'hFF : 8'h90, 8'(1 << k));
      tick(4);
`ifdef SEG_DECODE_EN
      chk("lit_hex", {32'd0, hex}, 64'h9999_999F);
      chk("lit_dec_err", {56'd0, dec_err}, 64'h01);
`endif
      chk("lit_img", dat, 64'h9090_9090_9090_90FF);

      for (int n = 0; n < 90; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            int len;
            len = $urandom_range(1, 19);
            if (len >= 16) len++;
            send_bits($urandom, len);
            latch();
         end else if (r == 1) begin
            send_frame(8'($urandom), 8'($urandom));
         end else begin
            int  k;
            logic [7:0] s;
            k = $urandom_range(0, 7);
            s = ($urandom_range(0, 1) == 1) ? digit_pat[$urandom_range(0, 9)] : 8'($urandom);
            send_frame(s, 8'(1 << k));
         end
      end
      tick(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
